ex_hazard_ctrl: RTL and testbench
=================================

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 SHALL take parameter REDIRECT_CYCLES, default 2: total cycles IFID is flushed after a mispredict, legal range 1..15.
REQ-002 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  single clock, all state rising-edge
- reset  in  1  asynchronous, active-low
REQ-003 SHALL have these EX-stage inputs:
- i_Valid_Bit  in  1  EX holds a valid instruction
- i_Rs1_addr, i_Rs2_addr  in  5 each  EX source addresses
- i_need_Rs1, i_need_Rs2  in  1 each  source used
REQ-004 SHALL have these MA/WB-stage inputs:
- i_MEM_Rds_addr  in  5  MA-stage destination
- i_MEM_RegWrite  in  1  MA-stage writes a register
- i_MEM_Load  in  1  MA instruction is a load
- i_WB_Rds_addr  in  5  WB-stage destination
- i_WB_RegWrite  in  1  WB-stage writes a register
REQ-005 SHALL have these control inputs:
- i_Mispredict  in  1  branch unit: PPC mismatch on the EX jump/branch
- i_Ext_Stall  in  1  memory not ready
REQ-006 SHALL have these forwarding and redirect outputs:
- o_Fwrd_Ctrl1, o_Fwrd_Ctrl2  out  2 each  00 register, 01 MEM, 10 WB
- o_NPC_Ctrl  out  1  select computed PC
REQ-007 SHALL have these pipeline-control outputs:
- o_PC_stall  out  1
- o_IFID_stall, o_IFID_flush  out  1 each
- o_IDEX_stall, o_IDEX_flush  out  1 each
- o_EXMA_stall, o_EXMA_flush  out  1 each
REQ-008 SHALL have these counter outputs:
- o_Stall_Cnt, o_Flush_Cnt  out  32 each  performance counters

Function
REQ-009 SHALL drive forwarding combinationally, per operand:
- 01 when need=1, MEM_RegWrite=1, MEM_Rds==Rs, Rs!=0
- else 10 when the same test passes against WB
- else 00
- MEM takes priority over WB; r0 is never forwarded
REQ-010 SHALL detect load-use (LU) when i_Valid_Bit=1, i_MEM_Load=1, MEM_Rds!=0, and a needed Rs equals MEM_Rds.
REQ-011 SHALL, on LU, assert o_PC_stall, o_IFID_stall, o_IDEX_stall and o_EXMA_flush in the same cycle, inserting exactly one bubble; next cycle the load sits in WB and forwarding selects 10.
REQ-012 SHALL implement an FSM with states RUN and REDIRECT plus a 4-bit down-counter rd_cnt.
REQ-013 SHALL, in RUN, when i_Valid_Bit & i_Mispredict & !LU:
- assert o_NPC_Ctrl, o_IFID_flush and o_IDEX_flush that cycle
- if REDIRECT_CYCLES>1, load rd_cnt=REDIRECT_CYCLES-1 and go to REDIRECT, else stay in RUN
REQ-014 SHALL, in REDIRECT:
- assert o_IFID_flush only, and decrement rd_cnt
- return to RUN when rd_cnt reaches 1 during that cycle
- a new qualified mispredict restarts per REQ-013
REQ-015 SHALL apply priority i_Ext_Stall > LU > mispredict > REDIRECT.
REQ-016 SHALL, while i_Ext_Stall=1:
- assert all *_stall outputs
- hold all flushes and o_NPC_Ctrl at 0
- freeze FSM state and rd_cnt
REQ-017 SHALL keep all stall, flush and NPC outputs at 0 when no condition is active.

Reset
REQ-018 SHALL, on reset low, immediately force:
- FSM=RUN, rd_cnt=0
- counters=0
- all control outputs 0; forwarding outputs stay combinational
REQ-019 SHALL abandon a mid-REDIRECT sequence on reset; the first cycle after release is RUN.

Configuration
REQ-020 SHALL, with macro HAZ_PERF_CNT_EN defined:
- o_Stall_Cnt increments every cycle any *_stall is 1
- o_Flush_Cnt increments every cycle any *_flush is 1
- both saturate at 32'hFFFFFFFF
REQ-021 SHALL, without HAZ_PERF_CNT_EN, keep both counter ports present, tied to 0, with no counter flops.

Structure
REQ-022 SHALL place FWD_REG/FWD_MEM/FWD_WB encodings and the FSM state encodings in the shared pipelinedefs package.
REQ-023 SHALL implement forwarding selection in one combinational sub-module, hz_fwd_sel, instantiated once per operand.

Verification
REQ-024 SHALL cover these directed scenarios:
- MEM_Rds=5, RegWrite=1; WB_Rds=5, RegWrite=1; Rs1=5, need_Rs1=1 -> o_Fwrd_Ctrl1=01.
- Rs2=0, MEM_Rds=0, RegWrite=1, need_Rs2=1 -> o_Fwrd_Ctrl2=00.
- MEM_Load=1, MEM_Rds=7, Rs1=7, valid -> one cycle of PC/IFID/IDEX stall + EXMA_flush; next cycle with WB_Rds=7 -> Fwrd_Ctrl1=10, no stall.
- Mispredict pulse, REDIRECT_CYCLES=3 -> NPC_Ctrl+IFID_flush+IDEX_flush cycle 0; IFID_flush cycles 1-2; idle cycle 3.
- Ext_Stall raised in REDIRECT with rd_cnt=2 for 4 cycles -> all stalls 1, flushes 0, rd_cnt stays 2; resumes after release.
- Reset asserted mid-REDIRECT -> outputs 0 asynchronously; RUN after release; with HAZ_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared pipeline definitions: forwarding-mux encodings and hazard FSM states.
package pipelinedefs;

  // Operand source select used by the EX-stage forwarding muxes
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // Redirect sequencer states
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } hz_state_e;

  localparam int RD_CNT_W = 4;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Bundle of EX/MA/WB hazard inputs and pipeline-control outputs.
// slave = the hazard controller, master = the surrounding pipeline (or bench).
interface ex_hazard_ctrl_if;
  logic        i_Valid_Bit;
  logic [4:0]  i_Rs1_addr;
  logic [4:0]  i_Rs2_addr;
  logic        i_need_Rs1;
  logic        i_need_Rs2;
  logic [4:0]  i_MEM_Rds_addr;
  logic        i_MEM_RegWrite;
  logic        i_MEM_Load;
  logic [4:0]  i_WB_Rds_addr;
  logic        i_WB_RegWrite;
  logic        i_Mispredict;
  logic        i_Ext_Stall;
  logic [1:0]  o_Fwrd_Ctrl1;
  logic [1:0]  o_Fwrd_Ctrl2;
  logic        o_NPC_Ctrl;
  logic        o_PC_stall;
  logic        o_IFID_stall;
  logic        o_IFID_flush;
  logic        o_IDEX_stall;
  logic        o_IDEX_flush;
  logic        o_EXMA_stall;
  logic        o_EXMA_flush;
  logic [31:0] o_Stall_Cnt;
  logic [31:0] o_Flush_Cnt;

  modport slave (
    input  i_Valid_Bit, i_Rs1_addr, i_Rs2_addr, i_need_Rs1, i_need_Rs2,
           i_MEM_Rds_addr, i_MEM_RegWrite, i_MEM_Load,
           i_WB_Rds_addr, i_WB_RegWrite, i_Mispredict, i_Ext_Stall,
    output o_Fwrd_Ctrl1, o_Fwrd_Ctrl2, o_NPC_Ctrl, o_PC_stall,
           o_IFID_stall, o_IFID_flush, o_IDEX_stall, o_IDEX_flush,
           o_EXMA_stall, o_EXMA_flush, o_Stall_Cnt, o_Flush_Cnt
  );

  modport master (
    output i_Valid_Bit, i_Rs1_addr, i_Rs2_addr, i_need_Rs1, i_need_Rs2,
           i_MEM_Rds_addr, i_MEM_RegWrite, i_MEM_Load,
           i_WB_Rds_addr, i_WB_RegWrite, i_Mispredict, i_Ext_Stall,
    input  o_Fwrd_Ctrl1, o_Fwrd_Ctrl2, o_NPC_Ctrl, o_PC_stall,
           o_IFID_stall, o_IFID_flush, o_IDEX_stall, o_IDEX_flush,
           o_EXMA_stall, o_EXMA_flush, o_Stall_Cnt, o_Flush_Cnt
  );
endinterface

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding selector. MEM wins over WB; r0 is never forwarded.
module hz_fwd_sel
  import pipelinedefs::*;
(
  input  logic       need_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] mem_rds_i,
  input  logic       mem_rw_i,
  input  logic [4:0] wb_rds_i,
  input  logic       wb_rw_i,
  output logic [1:0] fwd_o
);

  // Pick the youngest in-flight producer of this operand
  always_comb begin
    fwd_o = FWD_REG;
    if (need_i && (rs_i != 5'd0)) begin
      if (mem_rw_i && (mem_rds_i == rs_i))
        fwd_o = FWD_MEM;
      else if (wb_rw_i && (wb_rds_i == rs_i))
        fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding select, load-use bubble insertion,
// mispredict redirect sequencing and external-stall freeze.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush counters;
// without it the counter ports read constant zero.
module ex_hazard_ctrl
  import pipelinedefs::*;
#(
  parameter int REDIRECT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  ex_hazard_ctrl_if.slave   bus
);

  hz_state_e           state_q, state_d;
  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  logic load_use, mispredict;
  logic npc, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic exma_stall, exma_flush;

  hz_fwd_sel u_fwd1 (
    .need_i(bus.i_need_Rs1), .rs_i(bus.i_Rs1_addr),
    .mem_rds_i(bus.i_MEM_Rds_addr), .mem_rw_i(bus.i_MEM_RegWrite),
    .wb_rds_i(bus.i_WB_Rds_addr), .wb_rw_i(bus.i_WB_RegWrite),
    .fwd_o(bus.o_Fwrd_Ctrl1)
  );

  hz_fwd_sel u_fwd2 (
    .need_i(bus.i_need_Rs2), .rs_i(bus.i_Rs2_addr),
    .mem_rds_i(bus.i_MEM_Rds_addr), .mem_rw_i(bus.i_MEM_RegWrite),
    .wb_rds_i(bus.i_WB_Rds_addr), .wb_rw_i(bus.i_WB_RegWrite),
    .fwd_o(bus.o_Fwrd_Ctrl2)
  );

  // Load in MA whose destination a valid EX instruction still needs
  assign load_use = bus.i_Valid_Bit && bus.i_MEM_Load && (bus.i_MEM_Rds_addr != 5'd0) &&
                    ((bus.i_need_Rs1 && (bus.i_Rs1_addr == bus.i_MEM_Rds_addr)) ||
                     (bus.i_need_Rs2 && (bus.i_Rs2_addr == bus.i_MEM_Rds_addr)));
  assign mispredict = bus.i_Valid_Bit && bus.i_Mispredict && !load_use;

  // Redirect sequencer state and remaining-flush counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Prioritised control: ext stall > load-use > mispredict > redirect tail.
  // Ext stall and load-use both hold the sequencer where it is.
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    npc        = 1'b0;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    idex_flush = 1'b0;
    exma_stall = 1'b0;
    exma_flush = 1'b0;
    if (bus.i_Ext_Stall) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
      exma_stall = 1'b1;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
      exma_flush = 1'b1;
    end else if (mispredict) begin
      npc        = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (REDIRECT_CYCLES > 1) begin
        state_d  = ST_REDIRECT;
        rd_cnt_d = RD_CNT_W'(REDIRECT_CYCLES - 1);
      end else begin
        state_d  = ST_RUN;
        rd_cnt_d = '0;
      end
    end else if (state_q == ST_REDIRECT) begin
      ifid_flush = 1'b1;
      rd_cnt_d   = rd_cnt_q - 1'b1;
      if (rd_cnt_q == RD_CNT_W'(1))
        state_d = ST_RUN;
    end
  end

  // Control outputs are forced low for as long as reset is held
  assign bus.o_NPC_Ctrl   = reset & npc;
  assign bus.o_PC_stall   = reset & pc_stall;
  assign bus.o_IFID_stall = reset & ifid_stall;
  assign bus.o_IFID_flush = reset & ifid_flush;
  assign bus.o_IDEX_stall = reset & idex_stall;
  assign bus.o_IDEX_flush = reset & idex_flush;
  assign bus.o_EXMA_stall = reset & exma_stall;
  assign bus.o_EXMA_flush = reset & exma_flush;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        any_stall, any_flush;

  assign any_stall = pc_stall | ifid_stall | idex_stall | exma_stall;
  assign any_flush = ifid_flush | idex_flush | exma_flush;

  // Saturating per-cycle stall/flush counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (any_stall && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (any_flush && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.o_Stall_Cnt = stall_cnt_q;
  assign bus.o_Flush_Cnt = flush_cnt_q;
`else
  assign bus.o_Stall_Cnt = '0;
  assign bus.o_Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl (REDIRECT_CYCLES=3).
// Control vector order: {NPC, PC_stall, IFID_stall, IFID_flush,
//                        IDEX_stall, IDEX_flush, EXMA_stall, EXMA_flush}
module tb_ex_hazard_ctrl;

  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b0110_1001;
  localparam logic [7:0] C_EXT  = 8'b0110_1010;
  localparam logic [7:0] C_MP   = 8'b1001_0100;
  localparam logic [7:0] C_RD   = 8'b0001_0000;
  localparam logic [7:0] M_STL  = 8'b0110_1010;
  localparam logic [7:0] M_FLS  = 8'b0001_0101;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] exp_stall_cnt;
  logic [31:0] exp_flush_cnt;

  ex_hazard_ctrl_if bus ();

  ex_hazard_ctrl #(.REDIRECT_CYCLES(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctrl_vec();
    return {bus.o_NPC_Ctrl, bus.o_PC_stall, bus.o_IFID_stall, bus.o_IFID_flush,
            bus.o_IDEX_stall, bus.o_IDEX_flush, bus.o_EXMA_stall, bus.o_EXMA_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_Valid_Bit    = 1'b0;
    bus.i_Rs1_addr     = 5'd0;
    bus.i_Rs2_addr     = 5'd0;
    bus.i_need_Rs1     = 1'b0;
    bus.i_need_Rs2     = 1'b0;
    bus.i_MEM_Rds_addr = 5'd0;
    bus.i_MEM_RegWrite = 1'b0;
    bus.i_MEM_Load     = 1'b0;
    bus.i_WB_Rds_addr  = 5'd0;
    bus.i_WB_RegWrite  = 1'b0;
    bus.i_Mispredict   = 1'b0;
    bus.i_Ext_Stall    = 1'b0;
  endtask

  task automatic check_cnts(input string tag);
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, bus.o_Stall_Cnt, exp_stall_cnt);
    chk({tag, ".flush_cnt"}, bus.o_Flush_Cnt, exp_flush_cnt);
`else
    chk({tag, ".stall_cnt"}, bus.o_Stall_Cnt, 32'd0);
    chk({tag, ".flush_cnt"}, bus.o_Flush_Cnt, 32'd0);
`endif
  endtask

  // One clock cycle: inputs already driven; sample on the falling edge,
  // then advance to just past the next rising edge.
  task automatic step(input string tag, input logic [7:0] exp_ctrl,
                      input logic [1:0] exp_f1, input logic [1:0] exp_f2);
    @(negedge clk);
    check_cnts(tag);
    chk({tag, ".ctrl"}, {24'd0, ctrl_vec()}, {24'd0, exp_ctrl});
    chk({tag, ".fwd1"}, {30'd0, bus.o_Fwrd_Ctrl1}, {30'd0, exp_f1});
    chk({tag, ".fwd2"}, {30'd0, bus.o_Fwrd_Ctrl2}, {30'd0, exp_f2});
    $display("step %-14s ctrl=%b fwd1=%b fwd2=%b", tag, ctrl_vec(),
             bus.o_Fwrd_Ctrl1, bus.o_Fwrd_Ctrl2);
    if ((exp_ctrl & M_STL) != 8'd0) exp_stall_cnt = exp_stall_cnt + 32'd1;
    if ((exp_ctrl & M_FLS) != 8'd0) exp_flush_cnt = exp_flush_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    exp_stall_cnt = 32'd0;
    exp_flush_cnt = 32'd0;
    reset = 1'b0;
    idle();
    // Hazard requests while in reset must not reach the outputs
    bus.i_Valid_Bit  = 1'b1;
    bus.i_Mispredict = 1'b1;
    bus.i_Ext_Stall  = 1'b1;
    #3;
    chk("rst.ctrl", {24'd0, ctrl_vec()}, 32'd0);
    chk("rst.stall_cnt", bus.o_Stall_Cnt, 32'd0);
    chk("rst.flush_cnt", bus.o_Flush_Cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    idle();
    reset = 1'b1;

    step("idle0", C_IDLE, 2'b00, 2'b00);

    // MEM and WB both hold r5: MEM wins
    bus.i_Valid_Bit = 1'b1;
    bus.i_MEM_Rds_addr = 5'd5; bus.i_MEM_RegWrite = 1'b1;
    bus.i_WB_Rds_addr  = 5'd5; bus.i_WB_RegWrite  = 1'b1;
    bus.i_Rs1_addr = 5'd5; bus.i_need_Rs1 = 1'b1;
    step("fwd_mem_prio", C_IDLE, 2'b01, 2'b00);

    // r0 never forwarded
    idle();
    bus.i_Valid_Bit = 1'b1;
    bus.i_Rs2_addr = 5'd0; bus.i_need_Rs2 = 1'b1;
    bus.i_MEM_Rds_addr = 5'd0; bus.i_MEM_RegWrite = 1'b1;
    bus.i_WB_Rds_addr = 5'd0; bus.i_WB_RegWrite = 1'b1;
    step("fwd_r0", C_IDLE, 2'b00, 2'b00);

    // WB-only match on Rs2; Rs1 matches MEM but is not needed
    idle();
    bus.i_Valid_Bit = 1'b1;
    bus.i_Rs1_addr = 5'd3; bus.i_need_Rs1 = 1'b0;
    bus.i_Rs2_addr = 5'd9; bus.i_need_Rs2 = 1'b1;
    bus.i_MEM_Rds_addr = 5'd3; bus.i_MEM_RegWrite = 1'b1;
    bus.i_WB_Rds_addr = 5'd9; bus.i_WB_RegWrite = 1'b1;
    step("fwd_wb_noneed", C_IDLE, 2'b00, 2'b10);

    // MEM match without RegWrite falls through to WB
    idle();
    bus.i_Rs1_addr = 5'd12; bus.i_need_Rs1 = 1'b1;
    bus.i_MEM_Rds_addr = 5'd12; bus.i_MEM_RegWrite = 1'b0;
    bus.i_WB_Rds_addr = 5'd12; bus.i_WB_RegWrite = 1'b1;
    step("fwd_mem_norw", C_IDLE, 2'b10, 2'b00);

    // Load-use on r7: one bubble, then WB forwarding
    idle();
    bus.i_Valid_Bit = 1'b1;
    bus.i_MEM_Load = 1'b1; bus.i_MEM_Rds_addr = 5'd7; bus.i_MEM_RegWrite = 1'b1;
    bus.i_Rs1_addr = 5'd7; bus.i_need_Rs1 = 1'b1;
    step("lu_bubble", C_LU, 2'b01, 2'b00);
    bus.i_MEM_Load = 1'b0; bus.i_MEM_Rds_addr = 5'd0; bus.i_MEM_RegWrite = 1'b0;
    bus.i_WB_Rds_addr = 5'd7; bus.i_WB_RegWrite = 1'b1;
    step("lu_after", C_IDLE, 2'b10, 2'b00);

    // Load-use qualifier: invalid EX instruction gives no bubble
    idle();
    bus.i_MEM_Load = 1'b1; bus.i_MEM_Rds_addr = 5'd7; bus.i_MEM_RegWrite = 1'b1;
    bus.i_Rs2_addr = 5'd7; bus.i_need_Rs2 = 1'b1;
    step("lu_invalid", C_IDLE, 2'b00, 2'b01);

    // Load-use via Rs2 while a mispredict is also flagged: load-use wins
    bus.i_Valid_Bit = 1'b1; bus.i_Mispredict = 1'b1;
    step("lu_over_mp", C_LU, 2'b00, 2'b01);
    idle();
    step("lu_mp_idle", C_IDLE, 2'b00, 2'b00);

    // Ext stall over load-use
    bus.i_Valid_Bit = 1'b1; bus.i_Ext_Stall = 1'b1;
    bus.i_MEM_Load = 1'b1; bus.i_MEM_Rds_addr = 5'd4; bus.i_MEM_RegWrite = 1'b1;
    bus.i_Rs1_addr = 5'd4; bus.i_need_Rs1 = 1'b1;
    step("ext_over_lu", C_EXT, 2'b01, 2'b00);

    // Mispredict on invalid instruction is ignored
    idle();
    bus.i_Mispredict = 1'b1;
    step("mp_invalid", C_IDLE, 2'b00, 2'b00);

    // Mispredict with REDIRECT_CYCLES=3
    idle();
    bus.i_Valid_Bit = 1'b1; bus.i_Mispredict = 1'b1;
    step("mp_c0", C_MP, 2'b00, 2'b00);
    idle();
    step("mp_c1", C_RD, 2'b00, 2'b00);
    step("mp_c2", C_RD, 2'b00, 2'b00);
    step("mp_c3", C_IDLE, 2'b00, 2'b00);

    // Ext stall for 4 cycles with two redirect flushes outstanding
    bus.i_Valid_Bit = 1'b1; bus.i_Mispredict = 1'b1;
    step("mpx_c0", C_MP, 2'b00, 2'b00);
    idle();
    bus.i_Ext_Stall = 1'b1;
    step("ext_hold0", C_EXT, 2'b00, 2'b00);
    step("ext_hold1", C_EXT, 2'b00, 2'b00);
    step("ext_hold2", C_EXT, 2'b00, 2'b00);
    step("ext_hold3", C_EXT, 2'b00, 2'b00);
    bus.i_Ext_Stall = 1'b0;
    step("mpx_resume1", C_RD, 2'b00, 2'b00);
    step("mpx_resume2", C_RD, 2'b00, 2'b00);
    step("mpx_done", C_IDLE, 2'b00, 2'b00);

    // Reset asserted in the middle of a redirect
    bus.i_Valid_Bit = 1'b1; bus.i_Mispredict = 1'b1;
    step("mpr_c0", C_MP, 2'b00, 2'b00);
    idle();
    chk("mpr_c1.ifid_flush", {31'd0, bus.o_IFID_flush}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mpr_rst.ctrl", {24'd0, ctrl_vec()}, 32'd0);
    chk("mpr_rst.stall_cnt", bus.o_Stall_Cnt, 32'd0);
    chk("mpr_rst.flush_cnt", bus.o_Flush_Cnt, 32'd0);
    $display("async reset mid-redirect ctrl=%b", ctrl_vec());
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_stall_cnt = 32'd0;
    exp_flush_cnt = 32'd0;
    step("post_rst0", C_IDLE, 2'b00, 2'b00);
    step("post_rst1", C_IDLE, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
